mmu_region_unit: RTL and testbench

Parametrised, multi-region successor to the single-window address translator. Programs REGIONS translation windows through a configuration write port. Translates requests through a one-stage registered valid/ready pipeline and flags out-of-window accesses. Sits between the core's load/store or fetch address path and the bus.

---
 rtl/mmu_region_unit.sv | 140 ++++++++++++++
 tb/tb_mmu_region_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mmu_region_unit.sv
// Multi-region address translator: REGIONS programmable windows, priority match,
// one-stage registered valid/ready response and a saturating fault counter.
module mmu_region_unit #(
  parameter  int REGIONS   = 4,
  parameter  int XLEN      = 32,
  parameter  int CNT_WIDTH = 16,
  localparam int RW        = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [XLEN-1:0]      req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [XLEN-1:0]      rsp_addr_o,
  output logic                 rsp_exception_o,
  output logic [RW-1:0]        rsp_region_o,
  input  logic                 cfg_we_i,
  input  logic [RW-1:0]        cfg_region_i,
  input  logic [2:0]           cfg_field_i,
  input  logic [XLEN-1:0]      cfg_wdata_i,
  output logic [CNT_WIDTH-1:0] fault_count_o
);

  logic [XLEN-1:0] mask_q   [REGIONS];
  logic [XLEN-1:0] base_q   [REGIONS];
  logic [XLEN-1:0] size_q   [REGIONS];
  logic [XLEN-1:0] offset_q [REGIONS];
  logic [REGIONS-1:0] enable_q;
  logic [REGIONS-1:0] lock_q;

  logic            hit;
  logic [RW-1:0]   win;
  logic [XLEN-1:0] win_mask;
  logic [XLEN-1:0] win_size;
  logic [XLEN-1:0] win_offset;
  logic            fault;
  logic [XLEN-1:0] xlat_addr;
  logic            accept;
  logic            cfg_region_ok;
  logic            cnt_clear;

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Walk from the top index down so the lowest matching region overwrites the rest.
  always_comb begin
    hit        = 1'b0;
    win        = '0;
    win_mask   = '0;
    win_size   = '0;
    win_offset = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (enable_q[i] && ((req_addr_i & mask_q[i]) == base_q[i])) begin
        hit        = 1'b1;
        win        = RW'(i);
        win_mask   = mask_q[i];
        win_size   = size_q[i];
        win_offset = offset_q[i];
      end
    end
  end

  assign fault     = en_i && (!hit || ((req_addr_i & ~win_mask & ~win_size) != '0));
  assign xlat_addr = (req_addr_i & ~win_mask) | win_offset;

  always_comb begin
    cfg_region_ok = 1'b0;
    for (int i = 0; i < REGIONS; i++) begin
      if (cfg_region_i == RW'(i)) cfg_region_ok = 1'b1;
    end
  end

  assign cnt_clear = cfg_we_i && cfg_region_ok && (cfg_field_i == 3'd5);

  // Region register file; a lock freezes fields 0..4 until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGIONS; i++) begin
        mask_q[i]   <= '0;
        base_q[i]   <= '0;
        size_q[i]   <= '0;
        offset_q[i] <= '0;
      end
      enable_q <= '0;
      lock_q   <= '0;
    end else begin
      for (int i = 0; i < REGIONS; i++) begin
        if (cfg_we_i && (cfg_region_i == RW'(i)) && !lock_q[i]) begin
          case (cfg_field_i)
            3'd0: mask_q[i]   <= cfg_wdata_i;
            3'd1: base_q[i]   <= cfg_wdata_i;
            3'd2: size_q[i]   <= cfg_wdata_i;
            3'd3: offset_q[i] <= cfg_wdata_i;
            3'd4: begin
              enable_q[i] <= cfg_wdata_i[0];
              lock_q[i]   <= cfg_wdata_i[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_o     <= 1'b0;
      rsp_addr_o      <= '0;
      rsp_exception_o <= 1'b0;
      rsp_region_o    <= '0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      if (!en_i || fault) begin
        rsp_addr_o   <= req_addr_i;
        rsp_region_o <= '0;
      end else begin
        rsp_addr_o   <= xlat_addr;
        rsp_region_o <= win;
      end
      rsp_exception_o <= fault;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // A clear strobe takes precedence over a fault counted in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_count_o <= '0;
    end else if (cnt_clear) begin
      fault_count_o <= '0;
    end else if (accept && fault && (fault_count_o != '1)) begin
      fault_count_o <= fault_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_region_unit.sv
// Directed bench for mmu_region_unit: translation, priority, backpressure,
// lock, counter saturation/clear and asynchronous reset.
module tb_mmu_region_unit;

  localparam int REGIONS   = 3;
  localparam int XLEN      = 32;
  localparam int CNT_WIDTH = 4;
  localparam int RW        = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [XLEN-1:0]      req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [XLEN-1:0]      rsp_addr_o;
  logic                 rsp_exception_o;
  logic [RW-1:0]        rsp_region_o;
  logic                 cfg_we_i;
  logic [RW-1:0]        cfg_region_i;
  logic [2:0]           cfg_field_i;
  logic [XLEN-1:0]      cfg_wdata_i;
  logic [CNT_WIDTH-1:0] fault_count_o;

  int checks = 0;
  int errors = 0;

  mmu_region_unit #(.REGIONS(REGIONS), .XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .en_i(en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_addr_o(rsp_addr_o),
    .rsp_exception_o(rsp_exception_o), .rsp_region_o(rsp_region_o),
    .cfg_we_i(cfg_we_i), .cfg_region_i(cfg_region_i), .cfg_field_i(cfg_field_i),
    .cfg_wdata_i(cfg_wdata_i), .fault_count_o(fault_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input logic [RW-1:0] region, input logic [2:0] field, input logic [31:0] data);
    cfg_we_i     = 1'b1;
    cfg_region_i = region;
    cfg_field_i  = field;
    cfg_wdata_i  = data;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic en);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    en_i        = en;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] addr, input logic exc,
                          input logic [RW-1:0] region, input logic [CNT_WIDTH-1:0] cnt);
    checkOutput({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    checkOutput({tag, "_addr"}, rsp_addr_o, addr);
    checkOutput({tag, "_exc"}, 32'(rsp_exception_o), 32'(exc));
    checkOutput({tag, "_region"}, 32'(rsp_region_o), 32'(region));
    checkOutput({tag, "_count"}, 32'(fault_count_o), 32'(cnt));
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0;
    rsp_ready_i = 1'b1; cfg_we_i = 1'b0; cfg_region_i = '0; cfg_field_i = '0; cfg_wdata_i = '0;
    #1;
    checkOutput("reset_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_count", 32'(fault_count_o), 32'd0);
    checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
    #12 reset = 1'b0;

    cfgWrite(0, 3'd0, 32'hF000_0000);
    cfgWrite(0, 3'd1, 32'h2000_0000);
    cfgWrite(0, 3'd2, 32'h0000_0FFF);
    cfgWrite(0, 3'd3, 32'h8000_0000);
    cfgWrite(0, 3'd4, 32'h1);

    applyStimulus(32'h2000_0123, 1'b1);
    checkRsp("xlat", 32'h8000_0123, 1'b0, 0, 0);
    applyStimulus(32'h2000_1000, 1'b1);
    checkRsp("size_fault", 32'h2000_1000, 1'b1, 0, 1);
    applyStimulus(32'h3000_0000, 1'b1);
    checkRsp("nomatch", 32'h3000_0000, 1'b1, 0, 2);

    cfgWrite(1, 3'd0, 32'hF000_0000);
    cfgWrite(1, 3'd1, 32'h2000_0000);
    cfgWrite(1, 3'd2, 32'h0000_0FFF);
    cfgWrite(1, 3'd3, 32'h9000_0000);
    cfgWrite(1, 3'd4, 32'h1);
    applyStimulus(32'h2000_0010, 1'b1);
    checkRsp("prio0", 32'h8000_0010, 1'b0, 0, 2);
    cfgWrite(0, 3'd4, 32'h0);
    applyStimulus(32'h2000_0010, 1'b1);
    checkRsp("prio1", 32'h9000_0010, 1'b0, 1, 2);
    cfgWrite(0, 3'd4, 32'h1);

    // Backpressure: two accepted, stall three cycles with a third waiting, then drain
    req_valid_i = 1'b1; en_i = 1'b1; req_addr_i = 32'h2000_0001;
    tick();
    checkOutput("bp_r1", rsp_addr_o, 32'h8000_0001);
    req_addr_i = 32'h2000_0002;
    tick();
    checkOutput("bp_r2", rsp_addr_o, 32'h8000_0002);
    rsp_ready_i = 1'b0; req_addr_i = 32'h2000_0003;
    #1;
    checkOutput("bp_ready_low", 32'(req_ready_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("bp_hold_addr", rsp_addr_o, 32'h8000_0002);
      checkOutput("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("bp_hold_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    #1;
    checkOutput("bp_ready_high", 32'(req_ready_o), 32'd1);
    tick();
    checkOutput("bp_r3", rsp_addr_o, 32'h8000_0003);
    req_addr_i = 32'h2000_0004;
    tick();
    checkOutput("bp_r4", rsp_addr_o, 32'h8000_0004);
    req_valid_i = 1'b0;
    tick();
    checkOutput("bp_drained", 32'(rsp_valid_o), 32'd0);

    cfgWrite(0, 3'd4, 32'h3);
    cfgWrite(0, 3'd0, 32'h0000_0000);
    applyStimulus(32'h2000_0123, 1'b1);
    checkRsp("locked", 32'h8000_0123, 1'b0, 0, 2);

    cfgWrite(0, 3'd5, 32'h0);
    checkOutput("clear", 32'(fault_count_o), 32'd0);
    for (int k = 0; k < 15; k++) applyStimulus(32'h3000_0000, 1'b1);
    checkOutput("count_full", 32'(fault_count_o), 32'hF);
    applyStimulus(32'h3000_0000, 1'b1);
    checkOutput("count_sat", 32'(fault_count_o), 32'hF);

    cfg_we_i = 1'b1; cfg_region_i = 0; cfg_field_i = 3'd5;
    applyStimulus(32'h3000_0000, 1'b1);
    cfg_we_i = 1'b0;
    checkRsp("clear_wins", 32'h3000_0000, 1'b1, 0, 0);

    applyStimulus(32'h3000_0000, 1'b0);
    checkRsp("bypass_nomatch", 32'h3000_0000, 1'b0, 0, 0);
    applyStimulus(32'h2000_0123, 1'b0);
    checkRsp("bypass_match", 32'h2000_0123, 1'b0, 0, 0);

    applyStimulus(32'h3000_0000, 1'b1);
    checkOutput("pre_oor_count", 32'(fault_count_o), 32'd1);
    cfgWrite(2'd3, 3'd5, 32'h0);
    checkOutput("oor_ignored", 32'(fault_count_o), 32'd1);

    // Asynchronous reset while a faulting response is stalled
    rsp_ready_i = 1'b0;
    applyStimulus(32'h3000_0000, 1'b1);
    checkRsp("stall_pending", 32'h3000_0000, 1'b1, 0, 2);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("async_count", 32'(fault_count_o), 32'd0);
    checkOutput("async_addr", rsp_addr_o, 32'd0);
    checkOutput("async_exc", 32'(rsp_exception_o), 32'd0);
    #2 reset = 1'b0;
    rsp_ready_i = 1'b1;
    applyStimulus(32'h2000_0123, 1'b1);
    checkRsp("post_reset", 32'h2000_0123, 1'b1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
